// File: rtl/mem_wb_writeback_pkg.sv
// Shared pipeline definitions: datapath widths, load-size encodings and the
// MEM/WB stored-field payload.
package pipeline_defs;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

  typedef struct packed {
    logic                      reg_write;
    logic                      mem_to_reg;
    logic [1:0]                load_size;
    logic                      load_unsigned;
    logic [1:0]                byte_offset;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic [REG_ADDR_WIDTH-1:0] write_register;
  } wb_fields_t;

endpackage

// File: rtl/mem_wb_writeback_if.sv
// MEM/WB bus: MEM-stage results and pipeline control in, register-bank write
// port and retirement status out.
interface mem_wb_if
  import pipeline_defs::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
);
  logic                      stall;
  logic                      flush;
  logic                      in_valid;
  logic                      in_reg_write;
  logic                      in_mem_to_reg;
  logic [1:0]                in_load_size;
  logic                      in_load_unsigned;
  logic [1:0]                in_byte_offset;
  logic [DATA_WIDTH-1:0]     in_alu_result;
  logic [DATA_WIDTH-1:0]     in_mem_data;
  logic [REG_ADDR_WIDTH-1:0] in_write_register;

  logic [REG_ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0]     write_data;
  logic                      Reg_write;
  logic                      wb_valid;
  logic [COUNT_WIDTH-1:0]    retired_count;

  modport master (
    output stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_load_size,
           in_load_unsigned, in_byte_offset, in_alu_result, in_mem_data,
           in_write_register,
    input  write_register, write_data, Reg_write, wb_valid, retired_count
  );

  modport slave (
    input  stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_load_size,
           in_load_unsigned, in_byte_offset, in_alu_result, in_mem_data,
           in_write_register,
    output write_register, write_data, Reg_write, wb_valid, retired_count
  );
endinterface

// File: rtl/mem_wb_writeback_load_extend.sv
// Load formatter: picks the addressed byte/halfword lane of a memory word and
// sign- or zero-extends it to the datapath width.
module load_extend
  import pipeline_defs::*;
(
  input  logic [DATA_WIDTH-1:0] mem_word,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [1:0]            offset,
  output logic [DATA_WIDTH-1:0] data_c
);

  logic [15:0] half_c;
  logic [7:0]  byte_c;

  always_comb begin
    half_c = 16'h0000;
    byte_c = 8'h00;
    data_c = mem_word;

    // Little-endian lanes; offset[0] is ignored for halfwords.
    half_c = offset[1] ? mem_word[31:16] : mem_word[15:0];
    case (offset)
      2'd0:    byte_c = mem_word[7:0];
      2'd1:    byte_c = mem_word[15:8];
      2'd2:    byte_c = mem_word[23:16];
      default: byte_c = mem_word[31:24];
    endcase

    case (size)
      LS_HALF: data_c = {{16{~is_unsigned & half_c[15]}}, half_c};
      LS_BYTE: data_c = {{24{~is_unsigned & byte_c[7]}}, byte_c};
      LS_WORD: data_c = mem_word;
      default: data_c = mem_word;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with writeback formatting, r0 write suppression,
// stall/flush handling and a retired-instruction counter.
module mem_wb_writeback
  import pipeline_defs::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
)(
  input  logic   clk,
  input  logic   reset,
  mem_wb_if.slave bus
);

  wb_fields_t             in_f;
  wb_fields_t             fields_q;
  logic                   valid_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0]  ext_c;

  assign in_f = '{
    reg_write:      bus.in_reg_write,
    mem_to_reg:     bus.in_mem_to_reg,
    load_size:      bus.in_load_size,
    load_unsigned:  bus.in_load_unsigned,
    byte_offset:    bus.in_byte_offset,
    alu_result:     bus.in_alu_result,
    mem_data:       bus.in_mem_data,
    write_register: bus.in_write_register
  };

  // Flush only drops the incoming instruction; the one leaving WB still retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      fields_q <= '0;
      count_q  <= '0;
    end else begin
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (!bus.stall) begin
        valid_q  <= bus.in_valid;
        fields_q <= in_f;
      end
      if (valid_q && !bus.stall) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  load_extend u_load_extend (
    .mem_word    (fields_q.mem_data),
    .size        (fields_q.load_size),
    .is_unsigned (fields_q.load_unsigned),
    .offset      (fields_q.byte_offset),
    .data_c      (ext_c)
  );

  assign bus.write_register = fields_q.write_register;
  assign bus.write_data     = fields_q.mem_to_reg ? ext_c : fields_q.alu_result;
  assign bus.Reg_write      = valid_q & fields_q.reg_write & (|fields_q.write_register);
  assign bus.wb_valid       = valid_q;
  assign bus.retired_count  = count_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed vectors with literal expectations plus
// a per-cycle comparison against a behavioural model of the WB stage.
module tb_mem_wb_writeback;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  bit   started = 1'b0;

  mem_wb_if #(.COUNT_WIDTH(32)) bus ();

  mem_wb_writeback #(.COUNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model of what the WB stage holds.
  bit          m_valid, m_rw, m_m2r, m_uns;
  bit [1:0]    m_size, m_off;
  bit [31:0]   m_alu, m_mem, m_count;
  bit [4:0]    m_reg;

  function automatic bit [31:0] exp_wd();
    bit [31:0] f;
    if (!m_m2r) return m_alu;
    if (m_size == 2'b01) begin
      f = (m_mem >> (m_off[1] * 16)) & 32'h0000FFFF;
      if (!m_uns && f[15]) f = f | 32'hFFFF0000;
      return f;
    end
    if (m_size == 2'b10) begin
      f = (m_mem >> (m_off * 8)) & 32'h000000FF;
      if (!m_uns && f[7]) f = f | 32'hFFFFFF00;
      return f;
    end
    return m_mem;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_uns = 0; m_size = 0; m_off = 0;
      m_alu = 0; m_mem = 0; m_reg = 0; m_count = 0;
    end else begin
      if (m_valid && !bus.stall) m_count = m_count + 1;
      if (bus.flush) m_valid = 0;
      else if (!bus.stall) begin
        m_valid = bus.in_valid;       m_rw  = bus.in_reg_write;
        m_m2r   = bus.in_mem_to_reg;  m_size = bus.in_load_size;
        m_uns   = bus.in_load_unsigned; m_off = bus.in_byte_offset;
        m_alu   = bus.in_alu_result;  m_mem = bus.in_mem_data;
        m_reg   = bus.in_write_register;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("model.wb_valid", 32'(bus.wb_valid), 32'(m_valid));
      chk("model.Reg_write", 32'(bus.Reg_write), 32'(m_valid && m_rw && (m_reg != 0)));
      chk("model.write_register", 32'(bus.write_register), 32'(m_reg));
      chk("model.write_data", bus.write_data, exp_wd());
      chk("model.retired_count", bus.retired_count, m_count);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input bit v, input bit rw, input bit m2r, input bit [1:0] sz,
                        input bit uns, input bit [1:0] off, input bit [31:0] alu,
                        input bit [31:0] mem, input bit [4:0] rd);
    bus.in_valid = v;        bus.in_reg_write = rw;   bus.in_mem_to_reg = m2r;
    bus.in_load_size = sz;   bus.in_load_unsigned = uns; bus.in_byte_offset = off;
    bus.in_alu_result = alu; bus.in_mem_data = mem;   bus.in_write_register = rd;
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
    started = 1'b1;
    chk("reset.wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("reset.write_data", bus.write_data, 32'd0);
    chk("reset.retired_count", bus.retired_count, 32'd0);

    // ALU writeback to r31
    set_in(1, 1, 0, 2'b00, 0, 0, 32'h0000000A, 32'h0, 5'd31);
    cyc();
    chk("alu.Reg_write", 32'(bus.Reg_write), 32'd1);
    chk("alu.write_register", 32'(bus.write_register), 32'd31);
    chk("alu.write_data", bus.write_data, 32'd10);
    chk("alu.count_before", bus.retired_count, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("alu.count_after", bus.retired_count, 32'd1);

    // Byte loads, signed then unsigned
    set_in(1, 1, 1, 2'b10, 0, 2'd2, 32'h0, 32'h11F2A3B4, 5'd5);
    cyc();
    chk("lb.signed", bus.write_data, 32'hFFFFFFF2);
    bus.in_load_unsigned = 1'b1;
    cyc();
    chk("lbu.unsigned", bus.write_data, 32'h000000F2);

    // Halfword loads, upper then lower lane
    set_in(1, 1, 1, 2'b01, 0, 2'd2, 32'h0, 32'h80017FFF, 5'd6);
    cyc();
    chk("lh.upper", bus.write_data, 32'hFFFF8001);
    bus.in_byte_offset = 2'd0;
    cyc();
    chk("lh.lower", bus.write_data, 32'h00007FFF);

    // Write to r0 is suppressed but the instruction is valid
    set_in(1, 1, 0, 2'b00, 0, 0, 32'hDEADBEEF, 32'h0, 5'd0);
    cyc();
    chk("r0.Reg_write", 32'(bus.Reg_write), 32'd0);
    chk("r0.wb_valid", 32'(bus.wb_valid), 32'd1);

    // Stall holds WB for 3 cycles while inputs change
    set_in(1, 1, 0, 2'b00, 0, 0, 32'h00001234, 32'h0, 5'd7);
    cyc();
    chk("stall.count_entry", bus.retired_count, 32'd6);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 2'b10, 0, 2'(i), 32'h0000FFFF + 32'(i), 32'hA5A5A5A5, 5'd9);
      cyc();
      chk("stall.write_register", 32'(bus.write_register), 32'd7);
      chk("stall.write_data", bus.write_data, 32'h00001234);
      chk("stall.count", bus.retired_count, 32'd6);
    end
    bus.stall = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("stall.release_count", bus.retired_count, 32'd7);

    // Flush together with stall replaces the held instruction with a bubble
    set_in(1, 1, 0, 2'b00, 0, 0, 32'h00000055, 32'h0, 5'd3);
    cyc();
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    cyc();
    chk("flush.wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("flush.Reg_write", 32'(bus.Reg_write), 32'd0);
    chk("flush.count", bus.retired_count, 32'd7);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Word-size boundaries: size 11 is a word, odd halfword offset ignores bit 0
    set_in(1, 1, 1, 2'b11, 0, 2'd3, 32'h0, 32'hCAFEF00D, 5'd4);
    cyc();
    chk("lw.size11", bus.write_data, 32'hCAFEF00D);
    set_in(1, 1, 1, 2'b01, 1, 2'd3, 32'h0, 32'h9876ABCD, 5'd4);
    cyc();
    chk("lhu.offset3", bus.write_data, 32'h00009876);
    set_in(1, 1, 1, 2'b10, 0, 2'd3, 32'h0, 32'h80FFFFFF, 5'd4);
    cyc();
    chk("lb.offset3", bus.write_data, 32'hFFFFFF80);

    // Reset while WB holds a valid instruction
    reset = 1'b1;
    cyc();
    chk("rst.wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst.Reg_write", 32'(bus.Reg_write), 32'd0);
    chk("rst.write_data", bus.write_data, 32'd0);
    chk("rst.retired_count", bus.retired_count, 32'd0);
    reset = 1'b0;

    // Mixed traffic checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
             2'($urandom), $urandom, $urandom, 5'($urandom));
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      cyc();
    end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register plus writeback formatter for the 32-bit MIPS-style pipeline.
- Drives the register bank's write port: write_register, write_data and Reg_write.
- Captures memory-stage results and selects ALU result or load data, with byte/halfword extraction and sign/zero extension.
- Supports stall and flush, and keeps a retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- REG_ADDR_WIDTH, 5, register index width.
- COUNT_WIDTH, 32, retired-instruction counter width.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold the WB register contents
- flush  input  1  invalidate the instruction being captured
- in_valid  input  1  MEM stage holds a real instruction
- in_reg_write  input  1  instruction writes a register
- in_mem_to_reg  input  1  1 = load data, 0 = ALU result
- in_load_size  input  2  00 word, 01 half, 10 byte, 11 treated as word
- in_load_unsigned  input  1  1 = zero-extend, 0 = sign-extend
- in_byte_offset  input  2  low address bits of the load
- in_alu_result  input  DATA_WIDTH  ALU/address result
- in_mem_data  input  DATA_WIDTH  raw data-memory word
- in_write_register  input  REG_ADDR_WIDTH  destination register index
- write_register  output  REG_ADDR_WIDTH  to register bank
- write_data  output  DATA_WIDTH  to register bank and forwarding
- Reg_write  output  1  register bank write enable
- wb_valid  output  1  WB stage holds a valid instruction
- retired_count  output  COUNT_WIDTH  count of instructions retired

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - Reset is synchronous and active-high.
  - On reset, all stored fields are cleared, so wb_valid=0, Reg_write=0, write_register=0, write_data=0 and retired_count=0.
  - Reset takes priority over flush and stall. Reset mid-operation discards the held instruction, and no write occurs in the reset cycle's output.
- Pipeline register (on each rising edge, in priority order):
  - reset: clear everything.
  - else flush: valid_q<=0, other fields don't-care. Flush wins over stall.
  - else stall: all fields hold.
  - else: capture all in_* fields; valid_q<=in_valid.
- Latency: inputs presented in cycle N appear on the outputs in cycle N+1. Outputs are combinational from the stored fields only; there is no path from in_* to the outputs.
- Reg_write = valid_q & reg_write_q & (write_register != 0). A write to r0 is always suppressed.
- Stall with Reg_write=1: the register bank rewrites the same value each cycle. This is idempotent and permitted.
- write_data:
  - mem_to_reg_q=0: alu_q.
  - mem_to_reg_q=1, word (00 or 11): mem_q.
  - half: lane = byte_offset_q[1]; lane 0 = mem_q[15:0], lane 1 = mem_q[31:16]; extended to 32 bits.
  - byte: lane = byte_offset_q; byte k = mem_q[8k+7:8k], little-endian lane numbering; extended to 32 bits.
  - Sign extension replicates the top bit of the extracted field; zero extension pads with 0.
  - byte_offset_q[0] is ignored for halfwords; misalignment is not detected.
- retired_count:
  - Increments by 1 on each edge where valid_q=1 and stall=0 and reset=0, i.e. when the instruction leaves WB. Flush does not block this increment, because flush targets the incoming instruction.
  - Wraps modulo 2^COUNT_WIDTH.
- Simultaneous flush and stall: flush applies, and the held instruction is replaced by a bubble.

Decomposition:
- Shared package pipeline_defs holds:
  - Load-size encodings LS_WORD=2'b00, LS_HALF=2'b01, LS_BYTE=2'b10.
  - DATA_WIDTH and REG_ADDR_WIDTH constants.
- One natural sub-module, load_extend: purely combinational. Inputs are mem word, size, unsigned and offset; output is the extended 32-bit value. Reusable by a later MEM-stage forwarding path.

Test Plan:
- Reset, then in_valid=1, in_reg_write=1, mem_to_reg=0, alu=32'h0000000A, reg=31 -> next cycle Reg_write=1, write_register=31, write_data=10; retired_count becomes 1 one edge later.
- Load byte signed, mem=32'h11F2A3B4, offset=2 -> write_data=32'hFFFFFFF2. The same with unsigned -> 32'h000000F2.
- Load half signed, mem=32'h8001_7FFF, offset=2 -> 32'hFFFF8001. With offset=0 -> 32'h00007FFF.
- Write to reg 0 with alu=32'hDEADBEEF -> Reg_write=0, wb_valid=1.
- Valid instruction in WB, then stall=1 for 3 cycles while inputs change -> outputs are unchanged and retired_count is unchanged. Release stall -> count +1.
- flush=1 together with stall=1 -> wb_valid=0 and Reg_write=0 next cycle. Assert reset while wb_valid=1 -> all outputs 0 next cycle, retired_count=0.
